// File: rtl/crt_clock_pkg.sv
// Shared types and constants for the multi-channel CRT/timing clock generator.
package crt_clock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_t;

  localparam int DEFAULT_FREQ_W = 10;
  localparam int DIV_CYCLES     = DEFAULT_FREQ_W;
  localparam int SYS_MHZ        = 100;
  localparam int PIX_MHZ        = 25;

  // One quotient bit is resolved per cycle, so the iteration count equals the operand width.
  function automatic int divCycles(input int freqW);
    return freqW;
  endfunction

endpackage

// File: rtl/crt_freq_divider.sv
// Sequential restoring divider: Quotient = Dividend / (2*HalfDivisor), one bit per cycle.
//   state | meaning
//   IDLE  | waiting for Start; operands latched on Start
//   CALC  | one restoring-division step per cycle, FREQ_W steps
//   DONE  | result valid for exactly one cycle (Done=1)
module crt_freq_divider
  import crt_clock_pkg::*;
#(
  parameter int FREQ_W = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [FREQ_W-1:0] Dividend,
  input  logic [FREQ_W-1:0] HalfDivisor,
  output logic              Busy,
  output logic              Done,
  output logic [FREQ_W-1:0] Quotient,
  output logic              DivByZero
);

  localparam int ITER_W = $clog2(FREQ_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(divCycles(FREQ_W) - 1);

  divState_t state, stateNext;

  logic [FREQ_W-1:0] dvd;
  logic [FREQ_W-1:0] quo;
  logic [FREQ_W:0]   dvs;
  logic [FREQ_W:0]   rem;
  logic [FREQ_W+1:0] trial;
  logic [FREQ_W:0]   diff;
  logic              fits;
  logic [ITER_W-1:0] iter;
  logic              zeroFlag;

  assign trial = {rem, dvd[FREQ_W-1]};
  assign fits  = (trial >= {1'b0, dvs});
  // Remainder after a successful subtract always fits in FREQ_W+1 bits.
  assign diff  = trial[FREQ_W:0] - dvs;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Start) stateNext = CALC;
      CALC:    if (iter == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      iter     <= '0;
      zeroFlag <= 1'b0;
    end else if (state == IDLE && Start) begin
      dvd      <= Dividend;
      dvs      <= {HalfDivisor, 1'b0};
      rem      <= '0;
      quo      <= '0;
      iter     <= ITER_LAST;
      zeroFlag <= (HalfDivisor == '0);
    end else if (state == CALC) begin
      dvd  <= {dvd[FREQ_W-2:0], 1'b0};
      rem  <= fits ? diff : trial[FREQ_W:0];
      quo  <= {quo[FREQ_W-2:0], fits};
      iter <= iter - 1'b1;
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign Quotient  = quo;
  assign DivByZero = zeroFlag;

endmodule

// File: rtl/crt_clock_gen.sv
// NUM_CH run-time programmable divided clocks; new half-periods are adopted only at a toggle.
module crt_clock_gen
  import crt_clock_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int FREQ_W   = 10,
  parameter int CH_IDX_W = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Load,
  input  logic [CH_IDX_W-1:0] LoadChannel,
  input  logic [FREQ_W-1:0]   SystemClockFreq,
  input  logic [FREQ_W-1:0]   ChannelFreq,
  output logic                Busy,
  output logic                ConfigError,
  output logic [NUM_CH-1:0]   ClockOut,
  output logic [NUM_CH-1:0]   TickRise,
  output logic [NUM_CH-1:0]   Locked
);

  localparam logic [CH_IDX_W:0] NUM_CH_L = (CH_IDX_W + 1)'(NUM_CH);

  logic                divBusy;
  logic                divDone;
  logic                divZero;
  logic [FREQ_W-1:0]   quotient;
  logic                accept;
  logic                pendWrite;
  logic                resultBad;
  logic [CH_IDX_W-1:0] targetCh;
  logic                configErr;

  assign accept    = Load && !divBusy && ({1'b0, LoadChannel} < NUM_CH_L);
  assign resultBad = divZero || (quotient == '0);
  assign pendWrite = divDone && !resultBad;

  crt_freq_divider #(
    .FREQ_W(FREQ_W)
  ) uDivider (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (accept),
    .Dividend   (SystemClockFreq),
    .HalfDivisor(ChannelFreq),
    .Busy       (divBusy),
    .Done       (divDone),
    .Quotient   (quotient),
    .DivByZero  (divZero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      targetCh  <= '0;
      configErr <= 1'b0;
    end else begin
      if (accept) targetCh <= LoadChannel;
      if (divDone) configErr <= resultBad;
    end
  end

  assign Busy        = divBusy;
  assign ConfigError = configErr;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
    logic [FREQ_W-1:0] half;
    logic [FREQ_W-1:0] cnt;
    logic [FREQ_W-1:0] pending;
    logic              pendValid;
    logic              clkReg;
    logic              tickReg;
    logic              lockReg;
    logic              writeHere;

    assign writeHere = pendWrite && (targetCh == CH_IDX_W'(ch));

    always_ff @(posedge Clock) begin
      if (Reset) begin
        half      <= '0;
        cnt       <= FREQ_W'(1);
        pending   <= '0;
        pendValid <= 1'b0;
        clkReg    <= 1'b0;
        tickReg   <= 1'b0;
        lockReg   <= 1'b0;
      end else begin
        tickReg <= 1'b0;
        if (half == '0) begin
          clkReg <= 1'b0;
          cnt    <= FREQ_W'(1);
          if (pendValid) begin
            half      <= pending;
            pendValid <= 1'b0;
            lockReg   <= 1'b1;
          end
        end else if (cnt == half) begin
          clkReg  <= ~clkReg;
          tickReg <= ~clkReg;
          cnt     <= FREQ_W'(1);
          if (pendValid) begin
            half      <= pending;
            pendValid <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        // A result landing on a toggle cycle stays pending for the following toggle.
        if (writeHere) begin
          pending   <= quotient;
          pendValid <= 1'b1;
        end
      end
    end

    assign ClockOut[ch] = clkReg;
    assign TickRise[ch] = tickReg;
    assign Locked[ch]   = lockReg;
  end

endmodule

// File: tb/tb_crt_clock_gen.sv
// Directed bench for crt_clock_gen with hand-computed expectations.
module tb_crt_clock_gen;
  import crt_clock_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int FREQ_W   = 10;
  localparam int CH_IDX_W = 3;

  logic                Clock = 1'b0;
  logic                Reset;
  logic                Load;
  logic [CH_IDX_W-1:0] LoadChannel;
  logic [FREQ_W-1:0]   SystemClockFreq;
  logic [FREQ_W-1:0]   ChannelFreq;
  logic                Busy;
  logic                ConfigError;
  logic [NUM_CH-1:0]   ClockOut;
  logic [NUM_CH-1:0]   TickRise;
  logic [NUM_CH-1:0]   Locked;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  crt_clock_gen #(
    .NUM_CH  (NUM_CH),
    .FREQ_W  (FREQ_W),
    .CH_IDX_W(CH_IDX_W)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Load           (Load),
    .LoadChannel    (LoadChannel),
    .SystemClockFreq(SystemClockFreq),
    .ChannelFreq    (ChannelFreq),
    .Busy           (Busy),
    .ConfigError    (ConfigError),
    .ClockOut       (ClockOut),
    .TickRise       (TickRise),
    .Locked         (Locked)
  );

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic doLoad(input int ch, input int sys, input int freq);
    LoadChannel     = CH_IDX_W'(ch);
    SystemClockFreq = FREQ_W'(sys);
    ChannelFreq     = FREQ_W'(freq);
    Load = 1'b1;
    step();
    Load = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic measurePhases(input int ch, output int hi, output int lo);
    int w;
    w = 0;
    while (!TickRise[ch] && w < 200) begin
      w++;
      step();
    end
    if (w >= 200) begin
      hi = -1;
      lo = -1;
    end else begin
      hi = 0;
      while (ClockOut[ch] && hi < 200) begin
        hi++;
        step();
      end
      lo = 0;
      while (!ClockOut[ch] && lo < 200) begin
        lo++;
        step();
      end
    end
  endtask

  // Skips the run in progress at the start; counts completed runs and those differing from want.
  task automatic recordRuns(input int ch, input int cycles, input int want,
                            output int firstLen, output int nRuns, output int bad);
    logic prev;
    int   len;
    bit   first;
    prev = ClockOut[ch];
    len = 1;
    first = 1'b1;
    firstLen = -1;
    nRuns = 0;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (ClockOut[ch] == prev) begin
        len++;
      end else begin
        if (first) begin
          firstLen = len;
          first = 1'b0;
        end else begin
          nRuns++;
          if (len != want) bad++;
        end
        len = 1;
        prev = ClockOut[ch];
      end
    end
  endtask

  task automatic countHigh(input int ch, input int cycles, input bit useTick, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (useTick ? TickRise[ch] : ClockOut[ch]) n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, lo, first, nRuns, bad;
    Reset = 1'b1;
    Load = 1'b0;
    LoadChannel = '0;
    SystemClockFreq = '0;
    ChannelFreq = '0;
    step();
    step();
    Reset = 1'b0;

    checkValue("rst_busy", Busy, 0);
    checkValue("rst_cfgerr", ConfigError, 0);
    checkValue("rst_clockout", ClockOut, 0);
    checkValue("rst_tickrise", TickRise, 0);
    checkValue("rst_locked", Locked, 0);

    // ch0 at 100/25 -> H=2
    doLoad(0, SYS_MHZ, PIX_MHZ);
    waitIdle(n);
    checkValue("t1_busy_len", n, DIV_CYCLES + 1);
    checkValue("t1_lock_pre", Locked[0], 0);
    step();
    checkValue("t1_lock", Locked[0], 1);
    checkValue("t1_clk_a", ClockOut[0], 0);
    step();
    checkValue("t1_clk_b", ClockOut[0], 0);
    step();
    checkValue("t1_clk_c", ClockOut[0], 1);
    checkValue("t1_tick_c", TickRise[0], 1);
    step();
    checkValue("t1_clk_d", ClockOut[0], 1);
    checkValue("t1_tick_d", TickRise[0], 0);
    step();
    checkValue("t1_clk_e", ClockOut[0], 0);
    countHigh(0, 40, 1'b1, n);
    checkValue("t1_ticks_40", n, 10);
    measurePhases(0, hi, lo);
    checkValue("t1_hi", hi, 2);
    checkValue("t1_lo", lo, 2);
    checkValue("t1_ch1_off", Locked[1], 0);

    // ch0 retune 100/10 -> H=5, switch at next toggle
    doLoad(0, 100, 10);
    waitIdle(n);
    checkValue("t2_busy_len", n, 11);
    recordRuns(0, 60, 5, first, nRuns, bad);
    checkValue("t2_first_le2", int'(first >= 1 && first <= 2), 1);
    checkValue("t2_bad_runs", bad, 0);
    checkValue("t2_enough_runs", int'(nRuns >= 5), 1);
    measurePhases(0, hi, lo);
    checkValue("t2_hi", hi, 5);
    checkValue("t2_lo", lo, 5);
    checkValue("t2_cfgerr", ConfigError, 0);

    // ch1 zero frequency
    doLoad(1, 100, 0);
    waitIdle(n);
    checkValue("t3_zero_err", ConfigError, 1);
    checkValue("t3_zero_lock", Locked[1], 0);
    countHigh(1, 20, 1'b0, n);
    checkValue("t3_zero_clk", n, 0);
    // valid load on ch0 clears the sticky flag
    doLoad(0, 100, 25);
    waitIdle(n);
    checkValue("t3_clear_err", ConfigError, 0);
    // 100/120 -> Q=0
    doLoad(1, 100, 60);
    waitIdle(n);
    checkValue("t3_q0_err", ConfigError, 1);
    checkValue("t3_q0_lock", Locked[1], 0);
    countHigh(1, 20, 1'b0, n);
    checkValue("t3_q0_clk", n, 0);
    // out-of-range channel is ignored
    doLoad(5, 100, 25);
    checkValue("t3_badch_busy", Busy, 0);
    checkValue("t3_badch_err", ConfigError, 1);
    doLoad(1, 100, 50);
    waitIdle(n);
    checkValue("t3_ok_err", ConfigError, 0);
    measurePhases(1, hi, lo);
    checkValue("t3_ok_hi", hi, 1);
    checkValue("t3_ok_lo", lo, 1);
    checkValue("t3_ok_lock", Locked[1], 1);

    // Load during Busy is ignored
    applyReset();
    doLoad(0, 100, 25);
    step();
    step();
    LoadChannel     = CH_IDX_W'(1);
    SystemClockFreq = FREQ_W'(100);
    ChannelFreq     = FREQ_W'(50);
    Load = 1'b1;
    step();
    Load = 1'b0;
    waitIdle(n);
    checkValue("t4_busy_rest", n, 8);
    countHigh(1, 40, 1'b0, n);
    checkValue("t4_ch1_clk", n, 0);
    checkValue("t4_ch1_lock", Locked[1], 0);
    checkValue("t4_ch0_lock", Locked[0], 1);

    // Reset mid-divide
    doLoad(1, 100, 0);
    waitIdle(n);
    checkValue("t5_pre_err", ConfigError, 1);
    doLoad(0, 100, 25);
    step();
    step();
    step();
    step();
    checkValue("t5_busy_at5", Busy, 1);
    applyReset();
    checkValue("t5_busy", Busy, 0);
    checkValue("t5_cfgerr", ConfigError, 0);
    checkValue("t5_clockout", ClockOut, 0);
    checkValue("t5_tickrise", TickRise, 0);
    checkValue("t5_locked", Locked, 0);
    countHigh(0, 30, 1'b0, n);
    checkValue("t5_no_clk", n, 0);
    checkValue("t5_no_lock", Locked, 0);

    // Odd ratio 50/14 -> Q=3
    doLoad(0, 50, 7);
    waitIdle(n);
    checkValue("t6_cfgerr", ConfigError, 0);
    measurePhases(0, hi, lo);
    checkValue("t6_hi", hi, 3);
    checkValue("t6_lo", lo, 3);
    checkValue("t6_lock", Locked[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crt_clock_gen.md
Name: crt_clock_gen

Overview:
- Multi-channel successor to the single VGA pixel-clock divider.
- Generates NUM_CH independent divided clocks from Clock, each programmed at run time as a pair (SystemClockFreq, channel freq) in MHz.
- Computes the half-period with an on-chip sequential divider and applies new settings glitch-free at the channel's next toggle.
- Channel 0 drives the 25 MHz CRT pixel clock; further channels serve audio/tick timing for the Pong datapath.

Parameters:
- NUM_CH, 2, number of output clock channels (1..8).
- FREQ_W, 10, width of frequency operands in MHz (matches SystemClockSize).
- CH_IDX_W, 3, width of the channel-select input; must satisfy 2**CH_IDX_W >= NUM_CH.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  one-cycle request to reprogram one channel.
- LoadChannel  in  CH_IDX_W  target channel for Load.
- SystemClockFreq  in  FREQ_W  Clock frequency in MHz, sampled on Load.
- ChannelFreq  in  FREQ_W  requested output frequency in MHz, sampled on Load.
- Busy  out  1  divider computing; Load is ignored while high.
- ConfigError  out  1  sticky flag: last accepted Load was rejected.
- ClockOut  out  NUM_CH  divided clocks, registered.
- TickRise  out  NUM_CH  one-cycle strobe per channel on a 0->1 transition of ClockOut.
- Locked  out  NUM_CH  channel has a valid active half-period.

Behaviour:
- Reset values: ClockOut=0, TickRise=0, Busy=0, ConfigError=0, Locked=0.
- Reset also sets: all active half-periods H[ch]=0 (disabled), pending-valid flags cleared, counters=1, divider FSM to IDLE.
- Reset asserted mid-divide aborts the computation; no channel is updated.
- Divider FSM states:
  - IDLE: Load with Busy=0 and LoadChannel<NUM_CH latches the operands. Next state CALC; Busy=1 from the next cycle.
  - CALC: restoring division Q = SystemClockFreq / (2*ChannelFreq). Divisor is FREQ_W+1 bits; the loop runs exactly FREQ_W iterations, one per cycle, quotient truncated.
  - DONE (1 cycle): if ChannelFreq==0 or Q==0, set ConfigError=1 and leave the channel unchanged. Otherwise clear ConfigError, write pending[ch]=Q and set pend_valid[ch]. Return to IDLE; Busy=0 from the next cycle.
- Load latency: Load sampled at cycle t gives Busy high during t+1..t+FREQ_W+1. Result is visible in pending/ConfigError at t+FREQ_W+2.
- Rejected Loads (no effect, ConfigError unchanged):
  - Load while Busy=1.
  - LoadChannel>=NUM_CH.
- Per-channel counter, running every cycle:
  - If H[ch]!=0 and cnt==H[ch]: toggle ClockOut[ch] and set cnt=1. If pend_valid[ch] is set, also load H[ch]=pending[ch] and clear pend_valid[ch] in the same cycle.
  - Otherwise, if H[ch]!=0: cnt+1.
  - Output period is exactly 2*H clocks. Every high/low phase uses one H value, so no runt phase occurs on reconfiguration.
- Disabled channel (H==0): ClockOut held 0, cnt held 1. A pending value is adopted the next cycle and counting begins from cnt=1 with ClockOut=0.
- Pending overwrite: a second completed Load to the same channel before its toggle replaces pending; the last value wins.
- Simultaneous events: a DONE write to a channel in the same cycle that channel toggles is not adopted until the following toggle.
- TickRise[ch] is asserted in exactly the cycle in which ClockOut[ch] first reads 1; it is 0 otherwise.
- Locked[ch] = (H[ch]!=0), registered.
- Counter width is FREQ_W. Since Q <= 2**(FREQ_W-1), no counter wrap-around is reachable.

Decomposition:
- Package crt_clock_pkg holds:
  - divider FSM state encoding (IDLE, CALC, DONE);
  - helper constant DIV_CYCLES = FREQ_W;
  - default frequency constants SYS_MHZ=100, PIX_MHZ=25.
- Sub-module crt_freq_divider: sequential restoring divider with start/done handshake and a divide-by-zero flag.
- Per-channel counters are a generate loop in the top level.

Test Plan:
- Reset, then Load ch0 with (100,25). Required: Busy high for 11 cycles; then Locked[0]=1 and ClockOut[0] period 4 clocks, 2 high; TickRise[0] once per period.
- With ch0 running at 25, Load ch0 with (100,10). Required: switch at the next toggle; every phase is either 2 cycles (old) or 5 cycles (new), never shorter; steady period 10.
- Load ch1 with (100,0), then Load ch1 with (100,60). Required: ConfigError=1 after each; ClockOut[1] stays 0; Locked[1]=0. A following valid Load (100,50) clears ConfigError and gives a period of 2 clocks.
- Load ch0 (100,25), then pulse Load for ch1 on the 3rd Busy cycle. Required: the second Load is ignored and ch1 stays disabled.
- Load (100,25) ch0 and assert Reset at the 5th Busy cycle. Required: all outputs are at reset values one cycle later and no channel locks.
- Odd ratio (50,7): Q=3 and period 6 clocks; Locked=1.
